mul_arbiter: RTL and testbench

Two-requester arbiter and sequencer that shares one instance of the team's 4x4 combinational multiplier `mul` between two clients. It accepts operand pairs over valid/ready handshakes, holds them in operand registers for a configurable number of execute cycles (multicycle path budget), captures the 8-bit product, and returns it with a requester ID over a valid/ready response port. It sits between the operand-issuing front ends and the shared arithmetic datapath.

---
 rtl/mul_arbiter_if.sv | 41 ++++
 rtl/mul_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mul_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mul_arbiter_if
//  Purpose  : Handshake bundle between two operand requesters, the shared
//             multiplier sequencer and the product consumer.
//  Revision : 1.0  initial release
// ============================================================================
interface mul_arbiter_if;
    logic       req0_valid;
    logic       req0_ready;
    logic [3:0] req0_a;
    logic [3:0] req0_b;
    logic       req1_valid;
    logic       req1_ready;
    logic [3:0] req1_a;
    logic [3:0] req1_b;
    logic       resp_valid;
    logic       resp_ready;
    logic       resp_id;
    logic [7:0] resp_prod;
    logic       busy;

    // Requester / consumer side
    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_prod, busy
    );

    // Sequencer side
    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_prod, busy
    );
endinterface
`default_nettype wire

// File: rtl/mul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mul_arbiter (with leaf mul)
//  Purpose  : Two-requester arbiter/sequencer sharing one 4x4 combinational
//             multiplier. Operands are held for MUL_CYCLES execute cycles
//             before the product is captured and returned with the
//             requester ID.
//  Config   : MUL_ARB_RR_EN defined   -> round-robin arbitration
//             MUL_ARB_RR_EN undefined -> fixed priority, requester 0 first
//  Revision : 1.0  initial release
// ============================================================================

// Shared 4x4 unsigned combinational multiplier, full 8-bit result.
module mul (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] prod
);
    assign prod = {4'd0, a} * {4'd0, b};
endmodule

module mul_arbiter #(
    parameter int MUL_CYCLES = 1    // legal range 1..15
) (
    input  logic          clk,
    input  logic          rst_n,
    mul_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter starts at MUL_CYCLES-1 so that EXEC lasts exactly MUL_CYCLES cycles.
    localparam logic [3:0] CNT_LOAD = 4'(MUL_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic       op_id;
    logic [3:0] cnt;
    logic [7:0] prod_reg;
    logic [7:0] mul_prod;
    logic       grant0;
    logic       grant1;
    logic       accept;

`ifdef MUL_ARB_RR_EN
    // 1 means requester 1 was the last one accepted; reset value lets
    // requester 0 win the first contention.
    logic       last_grant;

    // Round-robin pick: contention goes to the requester not granted last.
    always_comb begin
        grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
        grant1 = bus.req1_valid && !grant0;
    end

    // Remember who was served on every accepted handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant1;
        end
    end
`else
    // Fixed priority pick: requester 0 always wins contention.
    always_comb begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid && !bus.req0_valid;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; ready is only offered in IDLE and
    // is suppressed while reset is asserted.
    always_comb begin
        state_next     = state;
        accept         = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.resp_valid = 1'b0;
        bus.busy       = 1'b1;
        case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (rst_n) begin
                    bus.req0_ready = grant0;
                    bus.req1_ready = grant1;
                    if (grant0 || grant1) begin
                        accept     = 1'b1;
                        state_next = EXEC;
                    end
                end
            end
            EXEC: begin
                if (cnt == 4'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                bus.busy   = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, execute-cycle countdown and product capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a     <= 4'd0;
            op_b     <= 4'd0;
            op_id    <= 1'b0;
            cnt      <= 4'd0;
            prod_reg <= 8'd0;
        end else begin
            if (accept) begin
                op_a  <= grant1 ? bus.req1_a : bus.req0_a;
                op_b  <= grant1 ? bus.req1_b : bus.req0_b;
                op_id <= grant1;
                cnt   <= CNT_LOAD;
            end else if (state == EXEC && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (state == EXEC && cnt == 4'd0) begin
                prod_reg <= mul_prod;
            end
        end
    end

    // Operand registers feed the multiplier for the whole execute window.
    mul u_mul (
        .a    (op_a),
        .b    (op_b),
        .prod (mul_prod)
    );

    assign bus.resp_prod = prod_reg;
    assign bus.resp_id   = op_id;

endmodule
`default_nettype wire

// File: tb/tb_mul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_arbiter
//  Purpose  : Self-checking bench for mul_arbiter: directed scenarios plus a
//             randomized run against a transaction-level reference model.
//             Build with MUL_ARB_RR_EN defined to exercise round-robin.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mul_arbiter;

    localparam int MC = 3;
`ifdef MUL_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mul_arbiter_if bus ();

    mul_arbiter #(.MUL_CYCLES(MC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       id;
        int         prod;
    } exp_t;

    // Phase convention: inputs change 1 time unit after a rising edge,
    // outputs are sampled 2 time units after it.

    task automatic drive_quiet();
        bus.req0_valid = 1'b0; bus.req0_a = 4'd0; bus.req0_b = 4'd0;
        bus.req1_valid = 1'b0; bus.req1_a = 4'd0; bus.req1_b = 4'd0;
        bus.resp_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Issue one op, wait for acceptance and the response; lat counts
    // cycles from the accept edge to the first cycle with resp_valid.
    task automatic run_one(input logic id, input logic [3:0] a, input logic [3:0] b,
                           output logic [7:0] p, output logic rid, output int lat);
        bit acc = 0;
        bit found = 0;
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
        end
        bus.resp_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            #1;
            acc = id ? bus.req1_ready : bus.req0_ready;
            @(posedge clk); #1;
            if (acc) break;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        lat = -1; p = 8'd0; rid = 1'b0;
        if (acc) begin
            for (int n = 1; n < 40; n++) begin
                #1;
                if (bus.resp_valid) begin
                    found = 1; lat = n; p = bus.resp_prod; rid = bus.resp_id;
                end
                @(posedge clk); #1;
                if (found) break;
            end
        end
    endtask

    task automatic test_reset();
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.resp_ready = 1'b1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        total++; if (bus.req0_ready !== 1'b0) begin bad++; $display("FAIL rst_req0_ready got=%0b want=0", bus.req0_ready); end
        total++; if (bus.req1_ready !== 1'b0) begin bad++; $display("FAIL rst_req1_ready got=%0b want=0", bus.req1_ready); end
        total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%0b want=0", bus.resp_valid); end
        total++; if (bus.resp_id !== 1'b0) begin bad++; $display("FAIL rst_resp_id got=%0b want=0", bus.resp_id); end
        total++; if (bus.resp_prod !== 8'h00) begin bad++; $display("FAIL rst_resp_prod got=%0h want=00", bus.resp_prod); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", bus.busy); end
        drive_quiet();
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic [7:0] p; logic rid; int lat;
        run_one(1'b0, 4'd7, 4'd9, p, rid, lat);
        total++; if (lat != MC + 1) begin bad++; $display("FAIL single_latency got=%0d want=%0d", lat, MC + 1); end
        total++; if (p !== 8'h3F) begin bad++; $display("FAIL single_prod got=%0h want=3f", p); end
        total++; if (rid !== 1'b0) begin bad++; $display("FAIL single_id got=%0b want=0", rid); end
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_idle_after got=%0b want=0", bus.busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_corner();
        logic [7:0] p; logic rid; int lat;
        run_one(1'b1, 4'd15, 4'd15, p, rid, lat);
        total++; if (lat != MC + 1) begin bad++; $display("FAIL corner_latency got=%0d want=%0d", lat, MC + 1); end
        total++; if (p !== 8'd225) begin bad++; $display("FAIL corner_max_prod got=%0h want=e1", p); end
        total++; if (rid !== 1'b1) begin bad++; $display("FAIL corner_max_id got=%0b want=1", rid); end
        run_one(1'b1, 4'd0, 4'd13, p, rid, lat);
        total++; if (p !== 8'd0) begin bad++; $display("FAIL corner_zero_prod got=%0h want=00", p); end
        total++; if (rid !== 1'b1) begin bad++; $display("FAIL corner_zero_id got=%0b want=1", rid); end
    endtask

    task automatic test_contention();
        int got = 0;
        logic ids [4];
        int   prods [4];
        int   exp_id;
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_a = 4'd3; bus.req0_b = 4'd5;
        bus.req1_valid = 1'b1; bus.req1_a = 4'd4; bus.req1_b = 4'd4;
        bus.resp_ready = 1'b1;
        for (int n = 0; n < 4 * (MC + 3) + 10 && got < 4; n++) begin
            #1;
            if (bus.resp_valid) begin
                ids[got] = bus.resp_id; prods[got] = int'(bus.resp_prod); got++;
            end
            @(posedge clk); #1;
        end
        drive_quiet();
        total++; if (got != 4) begin bad++; $display("FAIL contention_count got=%0d want=4", got); end
        for (int i = 0; i < got; i++) begin
            exp_id = RR ? (i % 2) : 0;
            total++; if (int'(ids[i]) != exp_id) begin bad++; $display("FAIL contention_id[%0d] got=%0d want=%0d", i, ids[i], exp_id); end
            total++; if (prods[i] != (exp_id == 1 ? 4 * 4 : 3 * 5)) begin bad++; $display("FAIL contention_prod[%0d] got=%0d want=%0d", i, prods[i], exp_id == 1 ? 16 : 15); end
        end
    endtask

    task automatic test_backpressure();
        bit found = 0;
        do_reset();
        bus.resp_ready = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = 4'd5; bus.req0_b = 4'd3;
        bus.req1_valid = 1'b1; bus.req1_a = 4'd6; bus.req1_b = 4'd7;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (bus.req0_ready) found = 1;
            @(posedge clk); #1;
            if (found) break;
        end
        bus.req0_valid = 1'b0;
        total++; if (!found) begin bad++; $display("FAIL bp_accept0 got=0 want=1"); end
        found = 0;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (bus.resp_valid) begin found = 1; break; end
            @(posedge clk); #1;
        end
        total++; if (!found) begin bad++; $display("FAIL bp_resp_timeout got=0 want=1"); end
        for (int c = 0; c < 5; c++) begin
            total++; if (bus.resp_valid !== 1'b1 || bus.resp_prod !== 8'd15 || bus.resp_id !== 1'b0) begin
                bad++; $display("FAIL bp_hold[%0d] got=v%0b p%0d id%0b want=v1 p15 id0", c, bus.resp_valid, bus.resp_prod, bus.resp_id);
            end
            total++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 || bus.busy !== 1'b1) begin
                bad++; $display("FAIL bp_stall[%0d] got=r%0b%0b busy%0b want=r00 busy1", c, bus.req0_ready, bus.req1_ready, bus.busy);
            end
            if (c == 4) bus.resp_ready = 1'b1;
            @(posedge clk); #2;
        end
        total++; if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0 || bus.req1_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release got=busy%0b v%0b r1%0b want=busy0 v0 r1", bus.busy, bus.resp_valid, bus.req1_ready);
        end
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL bp_next_accept got=%0b want=1", bus.busy); end
        found = 0;
        for (int n = 0; n < 40; n++) begin
            if (bus.resp_valid) begin found = 1; break; end
            @(posedge clk); #2;
        end
        total++; if (!found || bus.resp_prod !== 8'd42 || bus.resp_id !== 1'b1) begin
            bad++; $display("FAIL bp_second_resp got=f%0b p%0d id%0b want=f1 p42 id1", found, bus.resp_prod, bus.resp_id);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        int got = 0;
        logic ids [2];
        int   prods [2];
        bit d0, d1;
        // reset while executing
        bus.resp_ready = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_a = 4'd2; bus.req0_b = 4'd3;
        for (int n = 0; n < 20; n++) begin
            #1; if (bus.req0_ready) found = 1;
            @(posedge clk); #1;
            if (found) break;
        end
        bus.req0_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #2;
        total++; if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.resp_prod !== 8'd0) begin
            bad++; $display("FAIL rst_exec got=v%0b busy%0b p%0h want=v0 busy0 p00", bus.resp_valid, bus.busy, bus.resp_prod);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        // reset while a response is waiting
        bus.resp_ready = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_a = 4'd9; bus.req1_b = 4'd9;
        found = 0;
        for (int n = 0; n < 20; n++) begin
            #1; if (bus.req1_ready) found = 1;
            @(posedge clk); #1;
            if (found) break;
        end
        bus.req1_valid = 1'b0;
        found = 0;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (bus.resp_valid) begin found = 1; break; end
            @(posedge clk); #1;
        end
        total++; if (!found || bus.resp_prod !== 8'd81) begin bad++; $display("FAIL rst_resp_pre got=f%0b p%0d want=f1 p81", found, bus.resp_prod); end
        rst_n = 1'b0;
        @(posedge clk); #2;
        total++; if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.resp_prod !== 8'd0 || bus.resp_id !== 1'b0) begin
            bad++; $display("FAIL rst_resp got=v%0b busy%0b p%0h id%0b want=v0 busy0 p00 id0", bus.resp_valid, bus.busy, bus.resp_prod, bus.resp_id);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        // fresh contention after reset
        bus.resp_ready = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_a = 4'd2; bus.req0_b = 4'd6;
        bus.req1_valid = 1'b1; bus.req1_a = 4'd5; bus.req1_b = 4'd5;
        for (int n = 0; n < 4 * (MC + 3) + 10 && got < 2; n++) begin
            #1;
            d0 = bus.req0_valid && bus.req0_ready;
            d1 = bus.req1_valid && bus.req1_ready;
            if (bus.resp_valid) begin ids[got] = bus.resp_id; prods[got] = int'(bus.resp_prod); got++; end
            @(posedge clk); #1;
            if (d0) bus.req0_valid = 1'b0;
            if (d1) bus.req1_valid = 1'b0;
        end
        drive_quiet();
        total++; if (got != 2) begin bad++; $display("FAIL rst_after_count got=%0d want=2", got); end
        if (got == 2) begin
            total++; if (ids[0] !== 1'b0 || prods[0] != 2 * 6) begin bad++; $display("FAIL rst_after_first got=id%0b p%0d want=id0 p12", ids[0], prods[0]); end
            total++; if (ids[1] !== 1'b1 || prods[1] != 5 * 5) begin bad++; $display("FAIL rst_after_second got=id%0b p%0d want=id1 p25", ids[1], prods[1]); end
        end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        bit pend0 = 0, pend1 = 0, in_flight = 0, last_id = 1;
        logic [3:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
        int acc_iter = 0, done = 0, k = 0, skip0 = 0, skip1 = 0;
        bit e0, e1, r0, r1, rv, rr;
        do_reset();
        while ((done < 2000 || in_flight || pend0 || pend1) && k < 60000) begin
            if (done < 2000) begin
                if (!pend0 && $urandom_range(0, 1) == 1) begin
                    pend0 = 1; a0 = 4'($urandom_range(0, 15)); b0 = 4'($urandom_range(0, 15));
                end
                if (!pend1 && $urandom_range(0, 1) == 1) begin
                    pend1 = 1; a1 = 4'($urandom_range(0, 15)); b1 = 4'($urandom_range(0, 15));
                end
            end
            bus.req0_valid = pend0; bus.req0_a = a0; bus.req0_b = b0;
            bus.req1_valid = pend1; bus.req1_a = a1; bus.req1_b = b1;
            rr = ($urandom_range(0, 3) != 0);
            bus.resp_ready = rr;
            #1;
            r0 = bus.req0_ready; r1 = bus.req1_ready; rv = bus.resp_valid;
            e0 = !in_flight && pend0 && (!pend1 || !RR || last_id);
            e1 = !in_flight && pend1 && !e0;
            total++; if (r0 !== e0 || r1 !== e1) begin bad++; $display("FAIL rnd_grant k=%0d got=%0b%0b want=%0b%0b", k, r0, r1, e0, e1); end
            total++; if (bus.busy !== in_flight) begin bad++; $display("FAIL rnd_busy k=%0d got=%0b want=%0b", k, bus.busy, in_flight); end
            total++; if (rv !== (in_flight && k >= acc_iter + 1 + MC)) begin
                bad++; $display("FAIL rnd_resp_valid k=%0d got=%0b want=%0b", k, rv, in_flight && k >= acc_iter + 1 + MC);
            end
            if (rv === 1'b1) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL rnd_spurious_resp k=%0d got=1 want=0", k);
                end else if (bus.resp_id !== q[0].id || int'(bus.resp_prod) != q[0].prod) begin
                    bad++; $display("FAIL rnd_resp k=%0d got=id%0b p%0d want=id%0b p%0d", k, bus.resp_id, bus.resp_prod, q[0].id, q[0].prod);
                end
            end
            if (r0 && pend0) begin
                e.id = 1'b0; e.prod = int'(a0) * int'(b0); q.push_back(e);
                pend0 = 0; in_flight = 1; acc_iter = k; last_id = 0; skip0 = 0;
                if (pend1) skip1++;
            end else if (r1 && pend1) begin
                e.id = 1'b1; e.prod = int'(a1) * int'(b1); q.push_back(e);
                pend1 = 0; in_flight = 1; acc_iter = k; last_id = 1; skip1 = 0;
                if (pend0) skip0++;
            end
`ifdef MUL_ARB_RR_EN
            total++; if (skip0 > 1 || skip1 > 1) begin bad++; $display("FAIL rnd_starve k=%0d got=%0d,%0d want<=1", k, skip0, skip1); end
`endif
            if (rv && rr) begin
                if (q.size() != 0) void'(q.pop_front());
                in_flight = 0; done++;
            end
            @(posedge clk); #1;
            k++;
        end
        drive_quiet();
        total++; if (done < 2000) begin bad++; $display("FAIL rnd_ops_done got=%0d want>=2000", done); end
        total++; if (q.size() != 0) begin bad++; $display("FAIL rnd_unanswered got=%0d want=0", q.size()); end
    endtask

    initial begin
        drive_quiet();
        test_reset();
        test_single();
        test_corner();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
